pet_mood: RTL



---
 rtl/pet_pkg.sv | 38 +++
 rtl/pet_tick_gen.sv | 27 ++
 rtl/pet_mood.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pet_pkg.sv
// Shared types and constants for the pet status blocks: mood encodings,
// stat indices and the mood classification helper.
package pet_pkg;

    typedef enum logic [2:0] {
        MOOD_CONTENT  = 3'd0,
        MOOD_NEEDY    = 3'd1,
        MOOD_CRITICAL = 3'd2,
        MOOD_SLEEPING = 3'd3,
        MOOD_SICK     = 3'd4,
        MOOD_DEAD     = 3'd5
    } mood_e;

    localparam int NUM_STATS     = 6;
    localparam int STAT_HUNGER   = 0;
    localparam int STAT_HAPPY    = 1;
    localparam int STAT_HEALTH   = 2;
    localparam int STAT_HYGIENE  = 3;
    localparam int STAT_ENERGY   = 4;
    localparam int STAT_SOCIAL   = 5;

    // Mood from the worst need level alone (no sickness or sleep involved).
    function automatic mood_e classify_level(input logic [3:0] level,
                                             input logic [3:0] warn,
                                             input logic [3:0] crit);
        if (level >= crit)
            return MOOD_CRITICAL;
        else if (level >= warn)
            return MOOD_NEEDY;
        else
            return MOOD_CONTENT;
    endfunction

    function automatic logic mood_alerts(input mood_e m);
        return (m == MOOD_CRITICAL) || (m == MOOD_SICK);
    endfunction

endpackage

// File: rtl/pet_tick_gen.sv
// Evaluation tick divider: one-cycle tick every TICK_DIV clocks, with a
// synchronous clear that restarts the count from zero.
module pet_tick_gen #(
    parameter int TICK_DIV = 10000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] count_reg;

    assign tick = (count_reg == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count_reg <= '0;
        else if (clear || tick)
            count_reg <= '0;
        else
            count_reg <= count_reg + 1'b1;
    end

endmodule

// File: rtl/pet_mood.sv
// Pet mood classifier: evaluates the six need levels on each tick and
// publishes registered mood/alert status. Sleep support under PET_MOOD_SLEEP_EN.
module pet_mood
    import pet_pkg::*;
#(
    parameter int TICK_DIV    = 10000,
    parameter int WARN_LEVEL  = 8,
    parameter int CRIT_LEVEL  = 12,
    parameter int SLEEP_TICKS = 32,
    parameter int DEATH_TICKS = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] hunger,
    input  logic [3:0] happiness,
    input  logic [3:0] health,
    input  logic [3:0] hygiene,
    input  logic [3:0] energy,
    input  logic [3:0] social,
    input  logic       revive,
    output logic [2:0] mood,
    output logic       alert,
    output logic [5:0] alert_mask,
    output logic [2:0] worst_stat,
    output logic [7:0] age,
    output logic       dead
);

    localparam int          SW   = $clog2(DEATH_TICKS + 1);
    localparam logic [3:0]  WARN = 4'(WARN_LEVEL);
    localparam logic [3:0]  CRIT = 4'(CRIT_LEVEL);

    logic       tick;
    logic       revive_ok;
    logic [3:0] stats [NUM_STATS];
    logic [5:0] mask_now;
    logic [3:0] stat_max;
    logic [2:0] worst_idx;

    mood_e         mood_reg, mood_next;
    logic [SW-1:0] sick_cnt_reg, sick_cnt_next;
    logic [7:0]    age_reg, age_next;
    logic [5:0]    mask_reg, mask_next;
    logic [2:0]    worst_reg, worst_next;
    logic          alert_reg, dead_reg;

`ifdef PET_MOOD_SLEEP_EN
    localparam int LW = $clog2(SLEEP_TICKS + 1);
    logic [LW-1:0] sleep_cnt_reg, sleep_cnt_next;
`else
    logic unused_sleep_ticks;
    assign unused_sleep_ticks = (SLEEP_TICKS > 0);
`endif

    assign revive_ok = revive && (mood_reg == MOOD_DEAD);

    pet_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (revive_ok),
        .tick  (tick)
    );

    assign stats[STAT_HUNGER]  = hunger;
    assign stats[STAT_HAPPY]   = happiness;
    assign stats[STAT_HEALTH]  = health;
    assign stats[STAT_HYGIENE] = hygiene;
    assign stats[STAT_ENERGY]  = energy;
    assign stats[STAT_SOCIAL]  = social;

    generate
        for (genvar gi = 0; gi < NUM_STATS; gi++) begin : g_mask
            assign mask_now[gi] = (stats[gi] >= WARN);
        end
    endgenerate

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        stat_max  = stats[0];
        worst_idx = 3'd0;
        for (int i = 1; i < NUM_STATS; i++) begin
            if (stats[i] > stat_max) begin
                stat_max  = stats[i];
                worst_idx = 3'(i);
            end
        end
    end

    always_comb begin
        mood_next     = mood_reg;
        sick_cnt_next = sick_cnt_reg;
        age_next      = age_reg;
        mask_next     = mask_reg;
        worst_next    = worst_reg;
`ifdef PET_MOOD_SLEEP_EN
        sleep_cnt_next = sleep_cnt_reg;
`endif
        if (revive_ok) begin
            mood_next     = MOOD_CONTENT;
            age_next      = '0;
            sick_cnt_next = '0;
`ifdef PET_MOOD_SLEEP_EN
            sleep_cnt_next = '0;
`endif
        end else if (tick && (mood_reg != MOOD_DEAD)) begin
            mask_next  = mask_now;
            worst_next = worst_idx;
            age_next   = (age_reg == 8'hFF) ? age_reg : age_reg + 8'd1;
            if (health >= CRIT) begin
                sick_cnt_next = sick_cnt_reg + 1'b1;
                mood_next = (sick_cnt_next == SW'(DEATH_TICKS)) ? MOOD_DEAD : MOOD_SICK;
            end else begin
                sick_cnt_next = '0;
`ifdef PET_MOOD_SLEEP_EN
                // A finished episode falls through to classification, never straight back to sleep.
                if ((mood_reg == MOOD_SLEEPING) && (sleep_cnt_reg < LW'(SLEEP_TICKS - 1))) begin
                    sleep_cnt_next = sleep_cnt_reg + 1'b1;
                end else if ((energy >= CRIT) && (mood_reg != MOOD_SLEEPING)) begin
                    mood_next      = MOOD_SLEEPING;
                    sleep_cnt_next = '0;
                end else begin
                    mood_next = classify_level(stat_max, WARN, CRIT);
                end
`else
                mood_next = classify_level(stat_max, WARN, CRIT);
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mood_reg     <= MOOD_CONTENT;
            sick_cnt_reg <= '0;
            age_reg      <= '0;
            mask_reg     <= '0;
            worst_reg    <= '0;
            alert_reg    <= 1'b0;
            dead_reg     <= 1'b0;
        end else begin
            mood_reg     <= mood_next;
            sick_cnt_reg <= sick_cnt_next;
            age_reg      <= age_next;
            mask_reg     <= mask_next;
            worst_reg    <= worst_next;
            alert_reg    <= mood_alerts(mood_next);
            dead_reg     <= (mood_next == MOOD_DEAD);
        end
    end

`ifdef PET_MOOD_SLEEP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sleep_cnt_reg <= '0;
        else
            sleep_cnt_reg <= sleep_cnt_next;
    end
`endif

    assign mood       = mood_reg;
    assign alert      = alert_reg;
    assign alert_mask = mask_reg;
    assign worst_stat = worst_reg;
    assign age        = age_reg;
    assign dead       = dead_reg;

endmodule
